uart_rx_packet_parser: RTL and testbench

//  Consumer stage directly downstream of the UART RX FIFO. Pops bytes with a rx_data_valid/rx_data_read pop handshake.

---
 rtl/uart_rx_packet_parser.sv | 201 ++++++++++++++++++++
 tb/tb_uart_rx_packet_parser.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_packet_parser.sv
// Pops bytes from the UART RX FIFO, frames SOF/LEN/payload/CKSUM packets and streams the payload
// out on valid/ready, with per-packet done/error pulses and saturating packet counters.
//
// state   | meaning
// IDLE    | hunting for SOF_BYTE, everything else is dropped
// LEN     | SOF seen, next byte is the payload length
// PAYLOAD | forwarding payload bytes to the pkt_* stream
// CKSUM   | waiting for the 8-bit sum of LEN and payload
module uart_rx_packet_parser #(
  parameter int         DATA_WIDTH     = 9,
  parameter logic [7:0] SOF_BYTE       = 8'hA5,
  parameter int         MAX_PAYLOAD    = 64,
  parameter int         TIMEOUT_CYCLES = 100000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_data_valid,
  output logic                  rx_data_read,
  input  logic                  rx_line_error,
  output logic [7:0]            pkt_data,
  output logic                  pkt_valid,
  input  logic                  pkt_ready,
  output logic                  pkt_last,
  output logic                  pkt_done,
  output logic                  pkt_err,
  output logic [1:0]            err_code,
  output logic                  busy,
  output logic [15:0]           pkt_count,
  output logic [15:0]           err_count
);

  typedef enum logic [1:0] {S_IDLE, S_LEN, S_PAYLOAD, S_CKSUM} state_t;

  localparam int         TW      = $clog2(TIMEOUT_CYCLES + 1);
  // pkt_err lands exactly TIMEOUT_CYCLES cycles after the last pop (TIMEOUT_CYCLES >= 2)
  localparam logic [TW-1:0] TO_HIT = TW'(TIMEOUT_CYCLES - 2);
  localparam logic [7:0] MAX_LEN = 8'(MAX_PAYLOAD);
  localparam logic [1:0] ERR_CKSUM   = 2'd0;
  localparam logic [1:0] ERR_LEN     = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_LINE    = 2'd3;

  state_t        state_q, state_d;
  logic [7:0]    sum_q, sum_d;
  logic [7:0]    rem_q, rem_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          rd_q, rd_d;
  logic [7:0]    pkt_data_q, pkt_data_d;
  logic          pkt_valid_q, pkt_valid_d;
  logic          pkt_last_q, pkt_last_d;
  logic          pkt_done_q, pkt_done_d;
  logic          pkt_err_q, pkt_err_d;
  logic [1:0]    err_code_q, err_code_d;
  logic [15:0]   pkt_count_q, pkt_count_d;
  logic [15:0]   err_count_q, err_count_d;

  logic       stalled, pop, abort;
  logic [1:0] abort_code;
  logic [7:0] b;

  assign b       = rx_data[7:0];
  assign stalled = (state_q == S_PAYLOAD) && pkt_valid_q && !pkt_ready;
  assign pop     = !stalled && rx_data_valid && !rd_q && !rst;

  generate
    if (DATA_WIDTH > 8) begin : g_hi
      logic unused_hi;
      assign unused_hi = ^rx_data[DATA_WIDTH-1:8];
    end
  endgenerate

  always_comb begin
    state_d     = state_q;
    sum_d       = sum_q;
    rem_d       = rem_q;
    timer_d     = timer_q;
    rd_d        = pop;
    pkt_data_d  = pkt_data_q;
    pkt_valid_d = pkt_valid_q;
    pkt_last_d  = pkt_last_q;
    pkt_done_d  = 1'b0;
    pkt_err_d   = 1'b0;
    err_code_d  = err_code_q;
    pkt_count_d = pkt_count_q;
    err_count_d = err_count_q;
    abort       = 1'b0;
    abort_code  = ERR_CKSUM;

    if (pkt_valid_q && pkt_ready) begin
      pkt_valid_d = 1'b0;
      pkt_last_d  = 1'b0;
    end

    // only time spent waiting on the FIFO counts, not downstream backpressure
    if (state_q == S_IDLE || pop) begin
      timer_d = '0;
    end else if (!stalled) begin
      if (timer_q == TO_HIT) begin
        abort      = 1'b1;
        abort_code = ERR_TIMEOUT;
      end else begin
        timer_d = timer_q + 1'b1;
      end
    end

    if (pop) begin
      if (state_q != S_IDLE && rx_line_error) begin
        abort      = 1'b1;
        abort_code = ERR_LINE;
      end else begin
        case (state_q)
          S_IDLE: if (b == SOF_BYTE) state_d = S_LEN;
          S_LEN: begin
            sum_d = b;
            rem_d = b;
            if (b > MAX_LEN) begin
              abort      = 1'b1;
              abort_code = ERR_LEN;
            end else if (b == 8'd0) begin
              state_d = S_CKSUM;
            end else begin
              state_d = S_PAYLOAD;
            end
          end
          S_PAYLOAD: begin
            pkt_data_d  = b;
            pkt_valid_d = 1'b1;
            pkt_last_d  = (rem_q == 8'd1);
            sum_d       = sum_q + b;
            rem_d       = rem_q - 8'd1;
            if (rem_q == 8'd1) state_d = S_CKSUM;
          end
          S_CKSUM: begin
            state_d = S_IDLE;
            if (b == sum_q) begin
              pkt_done_d  = 1'b1;
              pkt_count_d = (pkt_count_q == 16'hFFFF) ? pkt_count_q : pkt_count_q + 16'd1;
            end else begin
              abort      = 1'b1;
              abort_code = ERR_CKSUM;
            end
          end
          default: state_d = S_IDLE;
        endcase
      end
    end

    if (abort) begin
      state_d     = S_IDLE;
      timer_d     = '0;
      pkt_err_d   = 1'b1;
      err_code_d  = abort_code;
      err_count_d = (err_count_q == 16'hFFFF) ? err_count_q : err_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      sum_q       <= '0;
      rem_q       <= '0;
      timer_q     <= '0;
      rd_q        <= 1'b0;
      pkt_data_q  <= '0;
      pkt_valid_q <= 1'b0;
      pkt_last_q  <= 1'b0;
      pkt_done_q  <= 1'b0;
      pkt_err_q   <= 1'b0;
      err_code_q  <= '0;
      pkt_count_q <= '0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      sum_q       <= sum_d;
      rem_q       <= rem_d;
      timer_q     <= timer_d;
      rd_q        <= rd_d;
      pkt_data_q  <= pkt_data_d;
      pkt_valid_q <= pkt_valid_d;
      pkt_last_q  <= pkt_last_d;
      pkt_done_q  <= pkt_done_d;
      pkt_err_q   <= pkt_err_d;
      err_code_q  <= err_code_d;
      pkt_count_q <= pkt_count_d;
      err_count_q <= err_count_d;
    end
  end

  assign rx_data_read = pop;
  assign pkt_data     = pkt_data_q;
  assign pkt_valid    = pkt_valid_q;
  assign pkt_last     = pkt_last_q;
  assign pkt_done     = pkt_done_q;
  assign pkt_err      = pkt_err_q;
  assign err_code     = err_code_q;
  assign busy         = (state_q != S_IDLE);
  assign pkt_count    = pkt_count_q;
  assign err_count    = err_count_q;

endmodule

// File: tb/tb_uart_rx_packet_parser.sv
// Bench for uart_rx_packet_parser: directed packet scenarios plus randomized packet streams
// checked against a packet-level expectation built while the stimulus is generated.
module tb_uart_rx_packet_parser;
  localparam int TO = 40;

  logic        clk = 1'b0;
  logic        rst;
  logic [8:0]  rx_data;
  logic        rx_data_valid, rx_data_read, rx_line_error;
  logic [7:0]  pkt_data;
  logic        pkt_valid, pkt_ready, pkt_last, pkt_done, pkt_err, busy;
  logic [1:0]  err_code;
  logic [15:0] pkt_count, err_count;

  uart_rx_packet_parser #(.DATA_WIDTH(9), .SOF_BYTE(8'hA5), .MAX_PAYLOAD(64), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_data_valid(rx_data_valid),
    .rx_data_read(rx_data_read), .rx_line_error(rx_line_error), .pkt_data(pkt_data),
    .pkt_valid(pkt_valid), .pkt_ready(pkt_ready), .pkt_last(pkt_last), .pkt_done(pkt_done),
    .pkt_err(pkt_err), .err_code(err_code), .busy(busy), .pkt_count(pkt_count),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int cyc = 0, pop_total = 0, last_pop_cyc = 0, err_cyc = 0;
  logic [9:0] fifo_q[$];            // {line_err, junk bit, byte}
  logic [8:0] got_beats[$], exp_beats[$];
  int         got_ev[$], exp_ev[$]; // 4 = done, 0..3 = err code
  logic       rd_seen, stall_prev = 1'b0;
  logic [7:0] prev_data = 8'h00;
  bit         rand_ready = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fifo_drive();
    if (fifo_q.size() > 0) begin
      rx_data_valid = 1'b1;
      rx_data       = fifo_q[0][8:0];
      rx_line_error = fifo_q[0][9];
    end else begin
      rx_data_valid = 1'b0;
      rx_data       = '0;
      rx_line_error = 1'b0;
    end
  endtask

  task automatic send(input logic [7:0] b, input logic le = 1'b0);
    logic junk;
    junk = 1'($urandom);
    fifo_q.push_back({le, junk, b});
    fifo_drive();
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
    if (rand_ready) pkt_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic exp_beat(input logic [7:0] d, input logic last);
    exp_beats.push_back({last, d});
  endtask

  task automatic clear_lists();
    got_beats.delete(); exp_beats.delete(); got_ev.delete(); exp_ev.delete();
  endtask

  task automatic do_reset();
    fifo_q.delete();
    fifo_drive();
    rst = 1'b1;
    repeat (3) tick();
    chk("reset_outputs", {busy, pkt_valid, pkt_last, pkt_done, pkt_err, rx_data_read, err_code,
                          pkt_data, pkt_count, err_count}, 32'd0);
    rst = 1'b0;
    clear_lists();
    pop_total = 0;
  endtask

  task automatic wait_idle(input int budget);
    int idle = 0;
    for (int i = 0; i < budget && idle < 4; i++) begin
      tick();
      if (fifo_q.size() == 0 && !busy && !pkt_valid) idle++;
      else idle = 0;
    end
    chk("idle_reached", 32'(idle >= 4), 32'd1);
  endtask

  task automatic compare_run(input string tag);
    chk({tag, "_beat_count"}, got_beats.size(), exp_beats.size());
    for (int i = 0; i < exp_beats.size() && i < got_beats.size(); i++)
      chk({tag, "_beat"}, 32'(got_beats[i]), 32'(exp_beats[i]));
    chk({tag, "_event_count"}, got_ev.size(), exp_ev.size());
    for (int i = 0; i < exp_ev.size() && i < got_ev.size(); i++)
      chk({tag, "_event"}, got_ev[i], exp_ev[i]);
  endtask

  // FIFO model: first-word fall-through, pop applied just after the edge that saw rx_data_read
  initial begin
    logic [9:0] tmp;
    forever begin
      @(posedge clk);
      rd_seen = rx_data_read;
      #1;
      if (rd_seen && fifo_q.size() > 0) tmp = fifo_q.pop_front();
      fifo_drive();
    end
  end

  // Output monitor, sampled mid-cycle
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (rx_data_read) begin
        pop_total++;
        last_pop_cyc = cyc;
      end
      if (pkt_valid && pkt_ready) got_beats.push_back({pkt_last, pkt_data});
      if (pkt_done) got_ev.push_back(4);
      if (pkt_err) begin
        got_ev.push_back(int'(err_code));
        err_cyc = cyc;
      end
      if (pkt_done || pkt_err) chk("done_err_exclusive", 32'(pkt_done && pkt_err), 32'd0);
      if (stall_prev) chk("beat_held", {23'd0, pkt_valid, pkt_data}, {23'd0, 1'b1, prev_data});
      stall_prev = pkt_valid && !pkt_ready;
      prev_data  = pkt_data;
    end
  end

  initial begin
    logic [7:0] pay[64];
    logic [7:0] sum, bad;
    int         len, kind, f, ndone, nerr, n;

    pkt_ready = 1'b1;
    fifo_drive();
    do_reset();

    // 1: good packet
    send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h69);
    exp_beat(8'h11, 0); exp_beat(8'h22, 0); exp_beat(8'h33, 1); exp_ev.push_back(4);
    wait_idle(200);
    compare_run("good");
    chk("good_counts", {pkt_count, err_count}, {16'd1, 16'd0});

    // 2: bad checksum
    do_reset();
    send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h68);
    exp_beat(8'h11, 0); exp_beat(8'h22, 0); exp_beat(8'h33, 1); exp_ev.push_back(0);
    wait_idle(200);
    compare_run("badck");
    chk("badck_counts", {pkt_count, err_count}, {16'd0, 16'd1});
    chk("badck_code_held", err_code, 2'd0);

    // 3: hunt plus empty packet
    do_reset();
    send(8'h00); send(8'hFF); send(8'h5A); send(8'hA5); send(8'h00); send(8'h00);
    exp_ev.push_back(4);
    wait_idle(200);
    compare_run("empty");
    chk("empty_counts", {pkt_count, err_count}, {16'd1, 16'd0});

    // 4: over-length then 1-byte packet
    do_reset();
    send(8'hA5); send(8'h41); send(8'hA5); send(8'h01); send(8'h07); send(8'h08);
    exp_ev.push_back(1); exp_ev.push_back(4); exp_beat(8'h07, 1);
    wait_idle(200);
    compare_run("len");
    chk("len_counts", {pkt_count, err_count}, {16'd1, 16'd1});
    chk("len_code_held", err_code, 2'd1);

    // 4b: LEN == MAX_PAYLOAD is legal
    do_reset();
    send(8'hA5); send(8'd64);
    sum = 8'd64;
    for (int i = 0; i < 64; i++) begin
      pay[i] = 8'($urandom);
      send(pay[i]);
      sum += pay[i];
      exp_beat(pay[i], i == 63);
    end
    send(sum);
    exp_ev.push_back(4);
    wait_idle(1000);
    compare_run("maxlen");

    // 5: backpressure
    do_reset();
    pkt_ready = 1'b0;
    send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h69);
    n = 0;
    while (!pkt_valid && n < 50) begin tick(); n++; end
    chk("bp_valid_seen", 32'(pkt_valid), 32'd1);
    chk("bp_pops_before", pop_total, 3);
    repeat (20) tick();
    chk("bp_pops_during_stall", pop_total, 3);
    chk("bp_data", pkt_data, 8'h11);
    chk("bp_busy", 32'(busy), 32'd1);
    pkt_ready = 1'b1;
    exp_beat(8'h11, 0); exp_beat(8'h22, 0); exp_beat(8'h33, 1); exp_ev.push_back(4);
    wait_idle(300);
    compare_run("bp");

    // 6: timeout
    do_reset();
    send(8'hA5); send(8'h02); send(8'h10);
    n = 0;
    while (got_ev.size() == 0 && n < TO + 60) begin tick(); n++; end
    chk("to_err_seen", got_ev.size(), 1);
    chk("to_latency", err_cyc - last_pop_cyc, TO);
    chk("to_code", err_code, 2'd2);
    tick();
    chk("to_busy", 32'(busy), 32'd0);
    exp_beat(8'h10, 0); exp_ev.push_back(2);
    compare_run("to");
    chk("to_counts", {pkt_count, err_count}, {16'd0, 16'd1});

    // 6b: reset mid-packet
    do_reset();
    send(8'hA5); send(8'h02); send(8'h10);
    n = 0;
    while (got_beats.size() == 0 && n < 50) begin tick(); n++; end
    repeat (10) tick();
    rst = 1'b1;
    tick();
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    repeat (TO + 20) tick();
    chk("rst_no_err", got_ev.size(), 0);
    chk("rst_err_count", err_count, 16'd0);
    send(8'hA5); send(8'h01); send(8'h07); send(8'h08);
    exp_beat(8'h10, 0); exp_beat(8'h07, 1); exp_ev.push_back(4);
    wait_idle(200);
    compare_run("rst");
    chk("rst_counts", {pkt_count, err_count}, {16'd1, 16'd0});

    // random packet stream with random backpressure
    do_reset();
    ndone = 0; nerr = 0;
    for (int p = 0; p < 40; p++) begin
      n = $urandom_range(0, 2);
      for (int k = 0; k < n; k++) begin
        bad = 8'($urandom);
        if (bad == 8'hA5) bad = 8'h5A;
        send(bad);
      end
      kind = $urandom_range(0, 9);
      len  = ($urandom_range(0, 9) == 0) ? 64 : $urandom_range(0, 12);
      for (int i = 0; i < len; i++) pay[i] = 8'($urandom);
      sum = 8'(len);
      for (int i = 0; i < len; i++) sum += pay[i];
      send(8'hA5);
      if (kind <= 6) begin
        send(8'(len));
        for (int i = 0; i < len; i++) begin send(pay[i]); exp_beat(pay[i], i == len - 1); end
        if (kind <= 4) begin
          send(sum); exp_ev.push_back(4); ndone++;
        end else begin
          send(sum + 8'($urandom_range(1, 255))); exp_ev.push_back(0); nerr++;
        end
      end else if (kind == 7) begin
        send(8'($urandom_range(65, 255))); exp_ev.push_back(1); nerr++;
      end else begin
        f = $urandom_range(0, len + 1);   // 0 = LEN, 1..len = payload, len+1 = CKSUM
        send(8'(len), f == 0);
        for (int i = 0; i < len && i + 1 <= f; i++) begin
          send(pay[i], i + 1 == f);
          if (i + 1 < f) exp_beat(pay[i], i == len - 1);
        end
        if (f == len + 1) send(sum, 1'b1);
        exp_ev.push_back(3); nerr++;
      end
    end
    rand_ready = 1'b1;
    wait_idle(20000);
    rand_ready = 1'b0;
    pkt_ready  = 1'b1;
    compare_run("rand");
    chk("rand_pkt_count", pkt_count, 16'(ndone));
    chk("rand_err_count", err_count, 16'(nerr));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
